// File: rtl/fpu_pkg.sv
// Shared opcodes, sequencer state encoding and divide defaults for the Fpu issue path.
package fpu_pkg;

    localparam int unsigned DIV_TIMEOUT_DEFAULT = 128;

    localparam logic [2:0] OP_MAD_PP = 3'b000;
    localparam logic [2:0] OP_MAD_PN = 3'b001;
    localparam logic [2:0] OP_MAD_NP = 3'b010;
    localparam logic [2:0] OP_MAD_NN = 3'b011;
    localparam logic [2:0] OP_DIV    = 3'b100;

    localparam logic [63:0] DIV_ZERO_POS = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] DIV_ZERO_NEG = 64'h8000_0000_0000_0000;

    typedef enum logic [2:0] {
        StIdle,
        StMad,
        StDivLaunch,
        StDivWait,
        StResp
    } state_e;

    // Saturate toward the sign of the dividend.
    function automatic logic [63:0] div_zero_result(input logic [63:0] a);
        return a[63] ? DIV_ZERO_NEG : DIV_ZERO_POS;
    endfunction

endpackage

// File: rtl/fpu_sequencer.sv
// Issue/writeback sequencer for an external Fpu: one request in flight, MAD is single-cycle,
// divide waits on fpu_busy with a bounded timeout.
module fpu_sequencer
    import fpu_pkg::*;
#(
    parameter int unsigned DIV_TIMEOUT = DIV_TIMEOUT_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [2:0]  req_op,
    input  logic [63:0] req_a,
    input  logic [63:0] req_b,
    input  logic [63:0] req_c,
    input  logic [4:0]  req_tag,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [63:0] resp_data,
    output logic [4:0]  resp_tag,
    output logic        resp_err,
    output logic [2:0]  fpu_op,
    output logic [63:0] fpu_a,
    output logic [63:0] fpu_b,
    output logic [63:0] fpu_c,
    input  logic        fpu_busy,
    input  logic [63:0] fpu_res
);

    localparam int unsigned CntW = $clog2(DIV_TIMEOUT + 1);

    state_e        state_q, state_d;
    logic [2:0]    op_q, op_d;
    logic [63:0]   a_q, a_d, b_q, b_d, c_q, c_d;
    logic [4:0]    tag_q, tag_d;
    logic [63:0]   data_q, data_d;
    logic          err_q, err_d;
    logic [CntW-1:0] busy_cnt_q, busy_cnt_d;
    logic          idle_seen_q, idle_seen_d;
    logic          accept;

    assign req_ready  = (state_q == StIdle) && !fpu_busy;
    assign accept     = req_valid && req_ready;
    assign resp_valid = (state_q == StResp);
    assign resp_data  = data_q;
    assign resp_tag   = tag_q;
    assign resp_err   = err_q;
    assign fpu_a      = a_q;
    assign fpu_b      = b_q;
    assign fpu_c      = c_q;

    always_comb begin
        state_d     = state_q;
        op_d        = op_q;
        a_d         = a_q;
        b_d         = b_q;
        c_d         = c_q;
        tag_d       = tag_q;
        data_d      = data_q;
        err_d       = err_q;
        busy_cnt_d  = busy_cnt_q;
        idle_seen_d = idle_seen_q;
        fpu_op      = OP_MAD_PP;

        unique case (state_q)
            StIdle: begin
                if (accept) begin
                    op_d        = req_op;
                    a_d         = req_a;
                    b_d         = req_b;
                    c_d         = req_c;
                    tag_d       = req_tag;
                    data_d      = '0;
                    err_d       = 1'b0;
                    busy_cnt_d  = '0;
                    idle_seen_d = 1'b0;
                    if (req_op <= OP_MAD_NN) begin
                        state_d = StMad;
                    end else if (req_op == OP_DIV && req_b != '0) begin
                        state_d = StDivLaunch;
                    end else begin
                        state_d = StResp;
                        err_d   = 1'b1;
                        data_d  = (req_op == OP_DIV) ? div_zero_result(req_a) : '0;
                    end
                end
            end
            StMad: begin
                fpu_op  = op_q;
                data_d  = fpu_res;
                state_d = StResp;
            end
            StDivLaunch: begin
                fpu_op  = OP_DIV;
                state_d = StDivWait;
            end
            StDivWait: begin
                fpu_op = OP_DIV;
                if (fpu_busy) begin
                    if (busy_cnt_q == CntW'(DIV_TIMEOUT - 1)) begin
                        err_d   = 1'b1;
                        data_d  = '0;
                        state_d = StResp;
                    end else begin
                        busy_cnt_d = busy_cnt_q + CntW'(1);
                    end
                end else if (busy_cnt_q != '0) begin
                    // Busy has fallen after being seen high: the quotient is valid now.
                    data_d  = fpu_res;
                    err_d   = 1'b0;
                    state_d = StResp;
                end else if (idle_seen_q) begin
                    err_d   = 1'b1;
                    data_d  = '0;
                    state_d = StResp;
                end else begin
                    idle_seen_d = 1'b1;
                end
            end
            StResp: begin
                if (resp_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            op_q        <= '0;
            a_q         <= '0;
            b_q         <= '0;
            c_q         <= '0;
            tag_q       <= '0;
            data_q      <= '0;
            err_q       <= 1'b0;
            busy_cnt_q  <= '0;
            idle_seen_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            op_q        <= op_d;
            a_q         <= a_d;
            b_q         <= b_d;
            c_q         <= c_d;
            tag_q       <= tag_d;
            data_q      <= data_d;
            err_q       <= err_d;
            busy_cnt_q  <= busy_cnt_d;
            idle_seen_q <= idle_seen_d;
        end
    end

endmodule

// File: tb/tb_fpu_sequencer.sv
// Scoreboard bench for fpu_sequencer with a behavioural Fpu stub (Q15 MAD, programmable divide).
module tb_fpu_sequencer;
    import fpu_pkg::*;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [2:0]  req_op = '0;
    logic [63:0] req_a = '0, req_b = '0, req_c = '0;
    logic [4:0]  req_tag = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b1;
    logic [63:0] resp_data;
    logic [4:0]  resp_tag;
    logic        resp_err;
    logic [2:0]  fpu_op;
    logic [63:0] fpu_a, fpu_b, fpu_c;
    logic        fpu_busy;
    logic [63:0] fpu_res;

    fpu_sequencer #(.DIV_TIMEOUT(128)) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_op    (req_op),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_c     (req_c),
        .req_tag   (req_tag),
        .resp_valid(resp_valid),
        .resp_ready(resp_ready),
        .resp_data (resp_data),
        .resp_tag  (resp_tag),
        .resp_err  (resp_err),
        .fpu_op    (fpu_op),
        .fpu_a     (fpu_a),
        .fpu_b     (fpu_b),
        .fpu_c     (fpu_c),
        .fpu_busy  (fpu_busy),
        .fpu_res   (fpu_res)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Fpu stub: each divide launch seen while idle makes busy high for div_cycles cycles.
    int div_cycles = 4;
    int busy_left;
    always @(posedge clk) begin
        if (reset) busy_left <= 0;
        else if (busy_left > 0) busy_left <= busy_left - 1;
        else if (fpu_op == OP_DIV) busy_left <= div_cycles;
    end
    assign fpu_busy = (busy_left > 0);

    logic signed [127:0] sa, sb2, sc, prod, quo;
    always_comb begin
        sa   = {{64{fpu_a[63]}}, fpu_a};
        sb2  = {{64{fpu_b[63]}}, fpu_b};
        sc   = {{64{fpu_c[63]}}, fpu_c};
        prod = (sa * sb2) >>> 15;
        quo  = (sb2 != 0) ? (sa <<< 15) / sb2 : '0;
        case (fpu_op)
            OP_MAD_PP: fpu_res = 64'(prod + sc);
            OP_MAD_PN: fpu_res = 64'(prod - sc);
            OP_MAD_NP: fpu_res = 64'(sc - prod);
            OP_MAD_NN: fpu_res = 64'(-prod - sc);
            OP_DIV:    fpu_res = 64'(quo);
            default:   fpu_res = '0;
        endcase
    end

    typedef struct {
        logic [63:0] data;
        logic [4:0]  tag;
        logic        err;
        int          lat;
        int          acc;
    } exp_t;

    exp_t exp_q[$];
    exp_t cur;
    int checks = 0;
    int failures = 0;
    int unexpected = 0;
    int div_op_seen = 0;
    int ready_viol = 0;
    bit holding = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] want);
        checks++;
        if (act !== want) begin
            failures++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, want, cyc);
        end
    endtask

    // Monitor: pops one expectation per response, then checks it stays put under backpressure.
    initial begin
        forever begin
            @(negedge clk);
            if (fpu_op == OP_DIV) div_op_seen++;
            if (req_ready && fpu_busy) ready_viol++;
            if (reset) begin
                holding = 0;
            end else if (resp_valid) begin
                if (!holding) begin
                    if (exp_q.size() == 0) begin
                        unexpected++;
                        check("unexpected_resp", 64'(resp_tag), 64'h0 - 1);
                    end else begin
                        cur = exp_q.pop_front();
                        check("resp_data", resp_data, cur.data);
                        check("resp_tag", 64'(resp_tag), 64'(cur.tag));
                        check("resp_err", 64'(resp_err), 64'(cur.err));
                        check("latency", 64'(cyc - cur.acc), 64'(cur.lat));
                    end
                    holding = 1;
                end else begin
                    check("hold_data", resp_data, cur.data);
                    check("hold_tag", 64'(resp_tag), 64'(cur.tag));
                    check("hold_ready_low", 64'(req_ready), 64'h0);
                end
                if (resp_ready) holding = 0;
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                         input logic [63:0] c, input logic [4:0] tag,
                         input logic [63:0] exp_data, input logic exp_err, input int exp_lat,
                         input bit push);
        int n;
        exp_t e;
        @(posedge clk);
        #1;
        req_valid = 1'b1;
        req_op = op;
        req_a = a;
        req_b = b;
        req_c = c;
        req_tag = tag;
        n = 0;
        @(negedge clk);
        while (!req_ready && n < 500) begin
            @(negedge clk);
            n++;
        end
        if (!req_ready) begin
            check("accept_timeout", 64'(req_ready), 64'h1);
        end else if (push) begin
            e.data = exp_data;
            e.tag  = tag;
            e.err  = exp_err;
            e.lat  = exp_lat;
            e.acc  = cyc;
            exp_q.push_back(e);
        end
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        @(negedge clk);
        while ((exp_q.size() != 0 || resp_valid || !req_ready) && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (n >= 400) check("drain_timeout", 64'(exp_q.size()), 64'h0);
    endtask

    task automatic wait_resp();
        int n;
        n = 0;
        @(negedge clk);
        while (!resp_valid && n < 400) begin
            @(negedge clk);
            n++;
        end
        if (!resp_valid) check("resp_timeout", 64'(resp_valid), 64'h1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_resp_valid", 64'(resp_valid), 64'h0);
        check("rst_resp_err", 64'(resp_err), 64'h0);
        check("rst_resp_data", resp_data, 64'h0);
        check("rst_resp_tag", 64'(resp_tag), 64'h0);
        check("rst_fpu_op", 64'(fpu_op), 64'h0);
        check("rst_fpu_abc", fpu_a | fpu_b | fpu_c, 64'h0);
        check("rst_req_ready", 64'(req_ready), 64'h1);

        // MAD variants: 2.0 * 3.0 +/- 1.0 in Q15.
        issue(3'b000, 64'h10000, 64'h18000, 64'h8000, 5'd5, 64'h38000, 1'b0, 2, 1);
        issue(3'b011, 64'h10000, 64'h18000, 64'h8000, 5'd6, 64'hFFFF_FFFF_FFFC_8000, 1'b0, 2, 1);
        issue(3'b001, 64'h10000, 64'h18000, 64'h8000, 5'd7, 64'h28000, 1'b0, 2, 1);
        issue(3'b010, 64'h10000, 64'h18000, 64'h8000, 5'd8, 64'hFFFF_FFFF_FFFD_8000, 1'b0, 2, 1);
        drain();

        // Divide 6.0 / 2.0 with 4 busy cycles; relaunch must hold off the next request.
        div_cycles = 4;
        issue(3'b100, 64'h30000, 64'h10000, 64'h0, 5'd9, 64'h18000, 1'b0, 7, 1);
        wait_resp();
        @(negedge clk);
        check("relaunch_busy", 64'(fpu_busy), 64'h1);
        check("relaunch_ready_low", 64'(req_ready), 64'h0);
        drain();

        // Errors: no Fpu divide activity allowed.
        div_op_seen = 0;
        issue(3'b100, 64'hFFFF_FFFF_FFFF_8000, 64'h0, 64'h0, 5'd10, 64'h8000_0000_0000_0000,
              1'b1, 1, 1);
        issue(3'b100, 64'h10000, 64'h0, 64'h0, 5'd11, 64'h7FFF_FFFF_FFFF_FFFF, 1'b1, 1, 1);
        issue(3'b111, 64'h10000, 64'h18000, 64'h8000, 5'd12, 64'h0, 1'b1, 1, 1);
        issue(3'b101, 64'h10000, 64'h18000, 64'h8000, 5'd13, 64'h0, 1'b1, 1, 1);
        drain();
        check("err_no_div_op", 64'(div_op_seen), 64'h0);

        // Backpressure: response held for 5 cycles with resp_ready low.
        @(posedge clk);
        #1 resp_ready = 1'b0;
        issue(3'b000, 64'h10000, 64'h18000, 64'h8000, 5'd14, 64'h38000, 1'b0, 2, 1);
        wait_resp();
        repeat (5) @(posedge clk);
        #1 resp_ready = 1'b1;
        drain();

        // Reset three cycles into the divide wait: nothing may come out.
        div_cycles = 20;
        issue(3'b100, 64'h30000, 64'h10000, 64'h0, 5'd15, 64'h0, 1'b0, 0, 0);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("midrst_resp_valid", 64'(resp_valid), 64'h0);
        check("midrst_fpu_op", 64'(fpu_op), 64'h0);
        check("midrst_req_ready", 64'(req_ready), 64'h1);
        repeat (40) @(negedge clk);
        check("midrst_no_resp", 64'(unexpected), 64'h0);

        // Busy stuck for the full timeout window.
        div_cycles = 128;
        issue(3'b100, 64'h30000, 64'h10000, 64'h0, 5'd16, 64'h0, 1'b1, 130, 1);
        drain();

        // Fpu never raises busy: gives up after two idle wait cycles.
        div_cycles = 0;
        issue(3'b100, 64'h30000, 64'h10000, 64'h0, 5'd17, 64'h0, 1'b1, 4, 1);
        drain();

        check("ready_vs_busy", 64'(ready_viol), 64'h0);
        check("scoreboard_empty", 64'(exp_q.size()), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
